// File: rtl/uart_pkg.sv
// Shared types and constants for the buffered UART transmitter.
package uart_pkg;

    localparam int UART_DATA_W          = 8;
    localparam int DEFAULT_CLKS_PER_BIT = 5208;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with combinational head output, latency 1 push-to-pop.
// A push while full is accepted only when a pop happens in the same cycle; otherwise it is dropped.
module sync_fifo #(
    parameter int W  = 8,
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic [W-1:0]  push_dat,
    input  logic          pop,
    output logic [W-1:0]  pop_dat,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
);

    localparam int DEPTH = 1 << AW;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign pop_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter: 8-entry FIFO feeding a framing FSM; line falls two edges after a push into an idle block.
// TX_READY low while the FIFO is full, except in the cycle the FSM pops, when a new byte can take the freed slot.
module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int FIFO_AW      = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [UART_DATA_W-1:0] TX_DATA,
    input  logic                   TX_EN,
    output logic                   TX_READY,
    output logic                   TX_STATUS,
    output logic                   UART_TXD
);

    localparam logic [13:0] LAST_TICK = 14'(CLKS_PER_BIT - 1);

    tx_state_t              state_q, state_d;
    logic [13:0]            baud_q, baud_d;
    logic [2:0]             bit_q, bit_d;
    logic [UART_DATA_W-1:0] shift_q, shift_d;
    logic                   txd_q, txd_d;
    logic                   status_q;
    logic                   bit_end;

    logic [UART_DATA_W-1:0] fifo_head;
    logic                   fifo_pop;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [FIFO_AW:0]       fifo_count;

    sync_fifo #(
        .W  (UART_DATA_W),
        .AW (FIFO_AW)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (TX_EN),
        .push_dat (TX_DATA),
        .pop      (fifo_pop),
        .pop_dat  (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    assign bit_end   = (baud_q == LAST_TICK);
    assign TX_READY  = !fifo_full || fifo_pop;
    assign TX_STATUS = status_q;
    assign UART_TXD  = txd_q;

    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        fifo_pop = 1'b0;
        txd_d    = 1'b1;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_head;
                    baud_d   = '0;
                    state_d  = START;
                end
            end
            START: begin
                txd_d  = 1'b0;
                baud_d = bit_end ? 14'd0 : baud_q + 14'd1;
                if (bit_end) begin
                    bit_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                txd_d  = shift_q[0];
                baud_d = bit_end ? 14'd0 : baud_q + 14'd1;
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = STOP;
                end
            end
            STOP: begin
                baud_d = bit_end ? 14'd0 : baud_q + 14'd1;
                if (bit_end) begin
                    // Chain straight into the next start bit when more data is waiting.
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        shift_d  = fifo_head;
                        state_d  = START;
                    end else begin
                        state_d  = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            txd_q    <= 1'b1;
            status_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            txd_q    <= txd_d;
            status_q <= (state_q == IDLE) && (fifo_count == '0);
        end
    end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Scoreboarded bench: directed pushes queue expected bytes, a line monitor decodes frames and compares.
module tb_uart_tx_buffered;

    localparam int CPB  = 4;
    localparam int CPB6 = 5208;

    logic       clk;
    logic       rst;
    logic [7:0] a_data;
    logic       a_en;
    logic       a_ready;
    logic       a_status;
    logic       a_txd;
    logic [7:0] b_data;
    logic       b_en;
    logic       b_ready;
    logic       b_status;
    logic       b_txd;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [7:0] exp_q[$];
    int         starts[$];

    uart_tx_buffered #(.CLKS_PER_BIT(CPB), .FIFO_AW(3)) dut_a (
        .clk       (clk),
        .reset     (rst),
        .TX_DATA   (a_data),
        .TX_EN     (a_en),
        .TX_READY  (a_ready),
        .TX_STATUS (a_status),
        .UART_TXD  (a_txd)
    );

    uart_tx_buffered dut_b (
        .clk       (clk),
        .reset     (rst),
        .TX_DATA   (b_data),
        .TX_EN     (b_en),
        .TX_READY  (b_ready),
        .TX_STATUS (b_status),
        .UART_TXD  (b_txd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    // Line monitor: decodes dut_a frames at mid-bit and pops the scoreboard.
    logic       in_frame = 1'b0;
    logic       prev_txd = 1'b1;
    int         mcnt     = 0;
    logic [9:0] fr;
    always @(negedge clk) begin
        if (rst) begin
            in_frame = 1'b0;
            prev_txd = 1'b1;
        end else begin
            if (!in_frame && prev_txd && !a_txd) begin
                in_frame = 1'b1;
                mcnt     = 0;
                starts.push_back(cyc);
            end
            if (in_frame) begin
                if (mcnt % CPB == CPB / 2) fr[mcnt / CPB] = a_txd;
                mcnt++;
                if (mcnt == 10 * CPB) begin
                    in_frame = 1'b0;
                    check("start_bit", {31'd0, fr[0]}, 32'd0);
                    check("stop_bit", {31'd0, fr[9]}, 32'd1);
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_frame: got %0h required no frame", fr[8:1]);
                    end else begin
                        check("rx_byte", {24'd0, fr[8:1]}, {24'd0, exp_q.pop_front()});
                    end
                end
            end
            prev_txd = a_txd;
        end
    end

    task automatic push_a(input logic [7:0] b);
        a_data = b;
        a_en   = 1'b1;
        @(posedge clk);
        #1;
        a_en   = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget, output int t);
        t = -1;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (a_status) begin
                t = cyc;
                break;
            end
        end
        if (t < 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: got timeout required TX_STATUS=1 within %0d cycles", name, budget);
        end
    endtask

    int         t_push, t_rise, t0, t_acc, acc, drop_k, lows, f6, hi6, rise6, r;
    logic       rdy;
    logic [9:0] bits6;

    initial begin
        rst = 1'b1; a_en = 1'b0; a_data = '0; b_en = 1'b0; b_data = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_txd", {31'd0, a_txd}, 32'd1);
        check("reset_ready", {31'd0, a_ready}, 32'd1);
        check("reset_status", {31'd0, a_status}, 32'd1);
        check("reset_b_txd", {31'd0, b_txd}, 32'd1);
        @(posedge clk); #1;

        // 1: single 0x55 frame and status timing
        starts.delete();
        exp_q.push_back(8'h55);
        push_a(8'h55);
        t_push = cyc;
        @(negedge clk);
        check("status_same_edge", {31'd0, a_status}, 32'd1);
        @(negedge clk);
        check("status_fall", {31'd0, a_status}, 32'd0);
        wait_idle("t1_idle", 200, t_rise);
        check("t1_frames", starts.size(), 1);
        if (starts.size() == 1) begin
            check("t1_fall_latency", starts[0] - t_push, 2);
            check("t1_status_40", t_rise - starts[0], 40);
        end
        check("t1_sb_empty", exp_q.size(), 0);

        // 2: three back-to-back frames
        @(posedge clk); #1;
        starts.delete();
        exp_q.push_back(8'h00); exp_q.push_back(8'hFF); exp_q.push_back(8'hA3);
        push_a(8'h00); push_a(8'hFF); push_a(8'hA3);
        wait_idle("t2_idle", 400, t_rise);
        check("t2_frames", starts.size(), 3);
        if (starts.size() == 3) begin
            check("t2_gap01", starts[1] - starts[0], 40);
            check("t2_gap12", starts[2] - starts[1], 40);
            check("t2_total", t_rise - starts[0], 120);
        end
        check("t2_sb_empty", exp_q.size(), 0);

        // 3: hold TX_EN with incrementing data until full
        @(posedge clk); #1;
        starts.delete();
        for (int i = 0; i < 9; i++) exp_q.push_back(8'h10 + 8'(i));
        acc = 0; drop_k = -1; t0 = -1;
        for (int k = 0; k < 20; k++) begin
            a_data = 8'h10 + 8'(k);
            a_en   = 1'b1;
            rdy    = a_ready;
            @(posedge clk);
            #1;
            if (k == 0) t0 = cyc;
            if (rdy) acc++;
            if (!rdy && drop_k < 0) drop_k = k;
        end
        a_en = 1'b0;
        check("t3_accepts", acc, 9);
        check("t3_drop_index", drop_k, 9);
        check("t3_ready_low", {31'd0, a_ready}, 32'd0);

        // 4: push while full in the cycle the FSM pops
        a_data = 8'hEE;
        a_en   = 1'b1;
        t_acc  = -1;
        for (int k = 0; k < 100; k++) begin
            rdy = a_ready;
            @(posedge clk);
            #1;
            if (rdy) begin
                t_acc = cyc;
                break;
            end
        end
        a_en = 1'b0;
        exp_q.push_back(8'hEE);
        check("t4_accept_at_pop", t_acc - t0, 41);
        check("t4_still_full", {31'd0, a_ready}, 32'd0);
        wait_idle("t4_idle", 800, t_rise);
        check("t4_frames", starts.size(), 10);
        if (starts.size() == 10) check("t4_contiguous", starts[9] - starts[0], 360);
        check("t4_sb_empty", exp_q.size(), 0);

        // 5: reset in the middle of 0xC3 with three bytes queued
        @(posedge clk); #1;
        push_a(8'hC3); push_a(8'h01); push_a(8'h02); push_a(8'h03);
        repeat (12) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        check("t5_txd", {31'd0, a_txd}, 32'd1);
        check("t5_ready", {31'd0, a_ready}, 32'd1);
        check("t5_status", {31'd0, a_status}, 32'd1);
        lows = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (!a_txd) lows++;
        end
        check("t5_line_quiet", lows, 0);
        check("t5_status_after", {31'd0, a_status}, 32'd1);

        // 6: default CLKS_PER_BIT, byte 0x41
        @(posedge clk); #1;
        b_data = 8'h41;
        b_en   = 1'b1;
        @(posedge clk);
        #1 b_en = 1'b0;
        t_push = cyc;
        f6 = -1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (!b_txd) begin
                f6 = cyc;
                break;
            end
        end
        if (f6 < 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL t6_start: got timeout required falling edge within 10 cycles");
        end else begin
            check("t6_fall_latency", f6 - t_push, 2);
            hi6 = -1; rise6 = -1; bits6 = '0;
            for (int k = 0; k < 10 * CPB6 + 4; k++) begin
                r = cyc - f6;
                if (hi6 < 0 && b_txd) hi6 = r;
                if (rise6 < 0 && b_status) rise6 = r;
                if ((r % CPB6) == CPB6 / 2 && (r / CPB6) < 10) bits6[r / CPB6] = b_txd;
                @(negedge clk);
            end
            check("t6_start_width", hi6, CPB6);
            check("t6_frame_len", rise6, 10 * CPB6);
            check("t6_start_bit", {31'd0, bits6[0]}, 32'd0);
            check("t6_byte", {24'd0, bits6[8:1]}, 32'h41);
            check("t6_stop_bit", {31'd0, bits6[9]}, 32'd1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
